// File: rtl/m68k_bus_ctrl_pkg.sv
// m68k_bus_ctrl_pkg.sv
// Shared state encoding, bus constants and the IPL priority encoder helper.
package m68k_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCESS = 3'd1,
      S_ACK    = 3'd2,
      S_IACK   = 3'd3,
      S_BERR   = 3'd4
   } bus_state_e;

   localparam logic [2:0] FC_IACK  = 3'b111;
   localparam logic [2:0] IPL_NONE = 3'b111;

   // Highest pending request level (bit i is level i+1), returned active low.
   function automatic logic [2:0] ipl_encode(input logic [6:0] irq);
      logic [2:0] lvl;
      lvl = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (irq[i]) begin
            lvl = 3'(i + 1);
         end
      end
      return ~lvl;
   endfunction

endpackage

// File: rtl/m68k_bus_ctrl_if.sv
// m68k_bus_ctrl_if.sv
// 68000 CPU-side bus: strobes, address/data and the acknowledge lines.
interface m68k_bus_ctrl_if #(
   parameter int ADDR_W = 24
);
   logic [ADDR_W-1:0] cpu_a;
   logic              cpu_as_n;
   logic              cpu_uds_n;
   logic              cpu_lds_n;
   logic              cpu_r_w_n;
   logic [2:0]        cpu_fc;
   logic [15:0]       cpu_d_out;
   logic [15:0]       cpu_d_in;
   logic              cpu_dtack_n;
   logic              cpu_berr_n;
   logic              cpu_vpa_n;
   logic [2:0]        cpu_ipl_n;

   modport master (
      output cpu_a, cpu_as_n, cpu_uds_n, cpu_lds_n,
      output cpu_r_w_n, cpu_fc, cpu_d_out,
      input  cpu_d_in, cpu_dtack_n, cpu_berr_n,
      input  cpu_vpa_n, cpu_ipl_n
   );

   modport slave (
      input  cpu_a, cpu_as_n, cpu_uds_n, cpu_lds_n,
      input  cpu_r_w_n, cpu_fc, cpu_d_out,
      output cpu_d_in, cpu_dtack_n, cpu_berr_n,
      output cpu_vpa_n, cpu_ipl_n
   );
endinterface

// File: rtl/m68k_bus_ctrl_ipl.sv
// m68k_bus_ctrl_ipl.sv
// Registers the priority-encoded interrupt level onto the active-low IPL bus.
module m68k_ipl_encoder
   import m68k_bus_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] irq,
   output logic [2:0] ipl_n
);
   logic [2:0] ipl_n_d;
   logic [2:0] ipl_n_q;

   // Encode the highest pending level.
   always_comb begin
      ipl_n_d = ipl_encode(irq);
   end

   // One-cycle registered IPL, idle level on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ipl_n_q <= IPL_NONE;
      end else begin
         ipl_n_q <= ipl_n_d;
      end
   end

   assign ipl_n = ipl_n_q;

endmodule

// File: rtl/m68k_bus_ctrl.sv
// m68k_bus_ctrl.sv
// 68000 bus glue: region decode, DTACK wait states, BERR watchdog, autovector IACK.
module m68k_bus_ctrl
   import m68k_bus_pkg::*;
#(
   parameter int NUM_REGIONS = 4,
   parameter int ADDR_W      = 24,
   parameter int WAIT_W      = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   m68k_bus_ctrl_if.slave                cpu,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_mask,
   input  logic [NUM_REGIONS*WAIT_W-1:0] region_wait,
   output logic [NUM_REGIONS-1:0]        mem_sel,
   output logic                          mem_rd,
   output logic                          mem_wr,
   output logic [1:0]                    mem_be,
   output logic [ADDR_W-2:0]             mem_addr,
   output logic [15:0]                   mem_wdata,
   input  logic [NUM_REGIONS*16-1:0]     mem_rdata,
   input  logic [NUM_REGIONS-1:0]        mem_ready,
   input  logic [6:0]                    irq,
   output logic                          iack_valid,
   output logic [2:0]                    iack_level
);
   localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
   localparam int TO_W  = $clog2(TIMEOUT);
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] A_CMP   = {{(ADDR_W-1){1'b1}}, 1'b0};

   bus_state_e state_q, state_d;

   logic [NUM_REGIONS-1:0] mem_sel_q, mem_sel_d;
   logic                   mem_rd_q, mem_rd_d;
   logic                   mem_wr_q, mem_wr_d;
   logic [1:0]             mem_be_q, mem_be_d;
   logic [ADDR_W-2:0]      mem_addr_q, mem_addr_d;
   logic [15:0]            mem_wdata_q, mem_wdata_d;
   logic [15:0]            d_in_q, d_in_d;
   logic                   dtack_n_q, dtack_n_d;
   logic                   berr_n_q, berr_n_d;
   logic                   vpa_n_q, vpa_n_d;
   logic                   iack_valid_q, iack_valid_d;
   logic [2:0]             iack_level_q, iack_level_d;
   logic [WAIT_W-1:0]      wait_q, wait_d;
   logic [TO_W-1:0]        to_q, to_d;
   logic [IDX_W-1:0]       idx_q, idx_d;

   logic                   cyc_start;
   logic                   hit;
   logic [IDX_W-1:0]       hit_idx;
   logic [NUM_REGIONS-1:0] hit_oh;
   logic [WAIT_W-1:0]      hit_wait;
   logic                   cur_ready;
   logic [15:0]            cur_rdata;

   assign cyc_start = ~cpu.cpu_as_n & (~cpu.cpu_uds_n | ~cpu.cpu_lds_n);

   // Region decode; scanning downwards lets the lowest matching index win.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      hit_oh  = '0;
      for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
         if ((((cpu.cpu_a ^ region_base[r*ADDR_W +: ADDR_W])
               & region_mask[r*ADDR_W +: ADDR_W]) & A_CMP) == '0) begin
            hit       = 1'b1;
            hit_idx   = IDX_W'(r);
            hit_oh    = '0;
            hit_oh[r] = 1'b1;
         end
      end
   end

   // Per-region muxes: wait count for the decoded hit, ready/data for the latched one.
   always_comb begin
      hit_wait  = '0;
      cur_ready = 1'b0;
      cur_rdata = '0;
      for (int r = 0; r < NUM_REGIONS; r++) begin
         if (hit_idx == IDX_W'(r)) begin
            hit_wait = region_wait[r*WAIT_W +: WAIT_W];
         end
         if (idx_q == IDX_W'(r)) begin
            cur_ready = mem_ready[r];
            cur_rdata = mem_rdata[r*16 +: 16];
         end
      end
   end

   // Bus cycle FSM: next state and registered outputs.
   always_comb begin
      state_d      = state_q;
      mem_sel_d    = mem_sel_q;
      mem_rd_d     = mem_rd_q;
      mem_wr_d     = mem_wr_q;
      mem_be_d     = mem_be_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      d_in_d       = d_in_q;
      dtack_n_d    = dtack_n_q;
      berr_n_d     = berr_n_q;
      vpa_n_d      = vpa_n_q;
      iack_valid_d = 1'b0;
      iack_level_d = iack_level_q;
      wait_d       = wait_q;
      to_d         = to_q;
      idx_d        = idx_q;

      unique case (state_q)
         S_IDLE: begin
            if (cyc_start) begin
               if (cpu.cpu_fc == FC_IACK) begin
                  state_d      = S_IACK;
                  vpa_n_d      = 1'b0;
                  iack_valid_d = 1'b1;
                  iack_level_d = cpu.cpu_a[3:1];
               end else if (hit) begin
                  state_d     = S_ACCESS;
                  mem_sel_d   = hit_oh;
                  mem_rd_d    = cpu.cpu_r_w_n;
                  mem_wr_d    = ~cpu.cpu_r_w_n;
                  mem_be_d    = {~cpu.cpu_uds_n, ~cpu.cpu_lds_n};
                  mem_addr_d  = cpu.cpu_a[ADDR_W-1:1];
                  mem_wdata_d = cpu.cpu_d_out;
                  wait_d      = hit_wait;
                  to_d        = '0;
                  idx_d       = hit_idx;
               end else begin
                  state_d  = S_BERR;
                  berr_n_d = 1'b0;
               end
            end
         end
         S_ACCESS: begin
            if (cpu.cpu_as_n) begin
               state_d   = S_IDLE;
               mem_sel_d = '0;
               mem_rd_d  = 1'b0;
               mem_wr_d  = 1'b0;
               mem_be_d  = '0;
            end else if (wait_q == '0 && cur_ready) begin
               state_d   = S_ACK;
               dtack_n_d = 1'b0;
               if (mem_rd_q) begin
                  d_in_d = cur_rdata;
               end
               mem_sel_d = '0;
               mem_rd_d  = 1'b0;
               mem_wr_d  = 1'b0;
               mem_be_d  = '0;
            end else if (to_q == TO_LAST) begin
               state_d   = S_BERR;
               berr_n_d  = 1'b0;
               mem_sel_d = '0;
               mem_rd_d  = 1'b0;
               mem_wr_d  = 1'b0;
               mem_be_d  = '0;
            end else begin
               to_d = to_q + 1'b1;
               if (wait_q != '0) begin
                  wait_d = wait_q - 1'b1;
               end
            end
         end
         S_ACK: begin
            if (cpu.cpu_as_n) begin
               state_d   = S_IDLE;
               dtack_n_d = 1'b1;
            end
         end
         S_BERR: begin
            if (cpu.cpu_as_n) begin
               state_d  = S_IDLE;
               berr_n_d = 1'b1;
            end
         end
         S_IACK: begin
            if (cpu.cpu_as_n) begin
               state_d = S_IDLE;
               vpa_n_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any cycle in flight without an ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         mem_sel_q    <= '0;
         mem_rd_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_be_q     <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         d_in_q       <= '0;
         dtack_n_q    <= 1'b1;
         berr_n_q     <= 1'b1;
         vpa_n_q      <= 1'b1;
         iack_valid_q <= 1'b0;
         iack_level_q <= '0;
         wait_q       <= '0;
         to_q         <= '0;
         idx_q        <= '0;
      end else begin
         state_q      <= state_d;
         mem_sel_q    <= mem_sel_d;
         mem_rd_q     <= mem_rd_d;
         mem_wr_q     <= mem_wr_d;
         mem_be_q     <= mem_be_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         d_in_q       <= d_in_d;
         dtack_n_q    <= dtack_n_d;
         berr_n_q     <= berr_n_d;
         vpa_n_q      <= vpa_n_d;
         iack_valid_q <= iack_valid_d;
         iack_level_q <= iack_level_d;
         wait_q       <= wait_d;
         to_q         <= to_d;
         idx_q        <= idx_d;
      end
   end

   m68k_ipl_encoder u_ipl (
      .clk   (clk),
      .reset (reset),
      .irq   (irq),
      .ipl_n (cpu.cpu_ipl_n)
   );

   assign cpu.cpu_d_in    = d_in_q;
   assign cpu.cpu_dtack_n = dtack_n_q;
   assign cpu.cpu_berr_n  = berr_n_q;
   assign cpu.cpu_vpa_n   = vpa_n_q;
   assign mem_sel         = mem_sel_q;
   assign mem_rd          = mem_rd_q;
   assign mem_wr          = mem_wr_q;
   assign mem_be          = mem_be_q;
   assign mem_addr        = mem_addr_q;
   assign mem_wdata       = mem_wdata_q;
   assign iack_valid      = iack_valid_q;
   assign iack_level      = iack_level_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// tb_m68k_bus_ctrl.sv
// Randomized scoreboard bench for the 68000 bus glue.
`timescale 1ns/1ps
module tb_m68k_bus_ctrl;
   localparam int NR = 4;
   localparam int AW = 24;
   localparam int WW = 4;
   localparam int TO = 64;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NR*AW-1:0]  region_base;
   logic [NR*AW-1:0]  region_mask;
   logic [NR*WW-1:0]  region_wait;
   logic [NR-1:0]     mem_sel;
   logic              mem_rd;
   logic              mem_wr;
   logic [1:0]        mem_be;
   logic [AW-2:0]     mem_addr;
   logic [15:0]       mem_wdata;
   logic [NR*16-1:0]  mem_rdata;
   logic [NR-1:0]     mem_ready;
   logic [6:0]        irq;
   logic              iack_valid;
   logic [2:0]        iack_level;

   m68k_bus_ctrl_if #(.ADDR_W(AW)) bus();

   m68k_bus_ctrl #(
      .NUM_REGIONS(NR), .ADDR_W(AW), .WAIT_W(WW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset), .cpu(bus),
      .region_base(region_base), .region_mask(region_mask),
      .region_wait(region_wait), .mem_sel(mem_sel), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .irq(irq), .iack_valid(iack_valid),
      .iack_level(iack_level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum {K_ACK, K_BERR, K_IACK, K_ABORT} kind_e;
   typedef struct {
      kind_e         kind;
      bit            acc;
      int            t0;
      int            resp;
      int            rel;
      logic [15:0]   data;
      logic [NR-1:0] sel;
      logic          rd;
      logic          wr;
      logic [1:0]    be;
      logic [AW-2:0] addr;
      logic [15:0]   wdata;
      logic [2:0]    lvl;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [15:0] last_din = '0;
   int          wait_cfg[NR] = '{0, 2, 1, 5};

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Level = bit length of the request vector; 0 means no request.
   function automatic logic [2:0] model_ipl(input logic [6:0] v);
      int n;
      int lvl;
      n = int'(v);
      lvl = 0;
      while (n > 0) begin
         n = n / 2;
         lvl++;
      end
      return ~3'(lvl);
   endfunction

   task automatic bus_cycle(input logic [23:0] a, input bit rw, input logic [1:0] ds_n,
                            input logic [2:0] fc, input logic [15:0] dout,
                            input int rdy_from, input int hold, input int abort_k,
                            input bit by_reset);
      exp_t e;
      int   r;
      int   k;
      int   last;
      r = (int'(a[23:20]) < NR) ? int'(a[23:20]) : -1;
      e.kind = K_BERR; e.acc = 1'b0; e.sel = '0; e.rd = 1'b0; e.wr = 1'b0;
      e.be = '0; e.addr = '0; e.wdata = '0; e.lvl = '0;
      @(negedge clk);
      e.t0 = cyc + 1;
      bus.cpu_a = a; bus.cpu_r_w_n = rw; bus.cpu_fc = fc; bus.cpu_d_out = dout;
      bus.cpu_uds_n = ds_n[1]; bus.cpu_lds_n = ds_n[0]; bus.cpu_as_n = 1'b0;
      mem_ready = '0;
      if (fc == 3'b111) begin
         e.kind = K_IACK; e.resp = e.t0; e.lvl = a[3:1];
      end else if (r < 0) begin
         e.kind = K_BERR; e.resp = e.t0;
      end else begin
         e.acc = 1'b1; e.sel[r] = 1'b1; e.rd = rw; e.wr = !rw; e.be = ~ds_n;
         e.addr = a[23:1]; e.wdata = dout;
         k = (wait_cfg[r] + 1 > rdy_from) ? wait_cfg[r] + 1 : rdy_from;
         if (k > TO) begin
            e.kind = K_BERR; k = TO;
         end else begin
            e.kind = K_ACK;
         end
         if (abort_k > 0 && abort_k < k) begin
            e.kind = K_ABORT; k = abort_k;
         end
         e.resp = e.t0 + k;
         if (e.kind == K_ACK && rw) last_din = mem_rdata[r*16 +: 16];
      end
      if (e.kind == K_ABORT && by_reset) last_din = '0;
      e.data = last_din;
      e.rel = e.resp + hold;
      exp_q.push_back(e);
      last = (e.kind == K_ABORT) ? e.resp : e.rel;
      for (int j = 1; j <= last - e.t0; j++) begin
         @(negedge clk);
         mem_ready = {NR{j >= rdy_from}};
         if (e.t0 + j == last) begin
            if (e.kind == K_ABORT && by_reset) reset = 1'b1;
            bus.cpu_as_n = 1'b1; bus.cpu_uds_n = 1'b1; bus.cpu_lds_n = 1'b1;
         end
      end
      @(negedge clk);
      reset = 1'b0;
      mem_ready = '0;
   endtask

   // Monitor: compares DUT events against the scoreboard queue.
   initial begin : monitor
      logic [NR-1:0] psel;
      logic pdt, pbe, pvp;
      exp_t cur;
      bit have_cur;
      kind_e ok;
      psel = '0; pdt = 1'b1; pbe = 1'b1; pvp = 1'b1; have_cur = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (psel == '0 && mem_sel != '0) begin
            check("access_start", (exp_q.size() > 0) ? exp_q[0].acc : 1'b0, 1'b1);
            if (exp_q.size() > 0 && exp_q[0].acc) begin
               check("start_cyc", cyc, exp_q[0].t0);
               check("strobes", {mem_sel, mem_rd, mem_wr, mem_be, mem_addr, mem_wdata},
                     {exp_q[0].sel, exp_q[0].rd, exp_q[0].wr, exp_q[0].be,
                      exp_q[0].addr, exp_q[0].wdata});
            end
         end
         if ((pdt && !bus.cpu_dtack_n) || (pbe && !bus.cpu_berr_n) ||
             (pvp && !bus.cpu_vpa_n)) begin
            ok = !bus.cpu_dtack_n ? K_ACK : (!bus.cpu_berr_n ? K_BERR : K_IACK);
            check("resp_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               cur = exp_q.pop_front();
               have_cur = 1'b1;
               check("resp_kind", ok, cur.kind);
               check("resp_cyc", cyc, cur.resp);
               check("strobes_clear", {mem_sel, mem_rd, mem_wr, mem_be}, 0);
               if (ok == K_ACK) check("cpu_d_in", bus.cpu_d_in, cur.data);
               if (ok == K_IACK) check("iack_pulse", {iack_valid, iack_level}, {1'b1, cur.lvl});
            end
         end else if (psel != '0 && mem_sel == '0) begin
            check("abort_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               cur = exp_q.pop_front();
               check("abort_kind", K_ABORT, cur.kind);
               check("abort_cyc", cyc, cur.resp);
               check("abort_idle", {bus.cpu_dtack_n, bus.cpu_berr_n, mem_rd, mem_wr}, 4'b1100);
            end
         end
         if (have_cur) begin
            if ((cur.kind == K_ACK && !pdt && bus.cpu_dtack_n) ||
                (cur.kind == K_BERR && !pbe && bus.cpu_berr_n) ||
                (cur.kind == K_IACK && !pvp && bus.cpu_vpa_n)) begin
               check("release_cyc", cyc, cur.rel);
               have_cur = 1'b0;
            end else if (cur.kind == K_IACK && !pvp && !bus.cpu_vpa_n) begin
               check("iack_hold", {iack_valid, iack_level, mem_sel}, {1'b0, cur.lvl, 4'b0});
            end
         end
         if (!reset) check("ipl", bus.cpu_ipl_n, model_ipl(irq));
         psel = mem_sel; pdt = bus.cpu_dtack_n; pbe = bus.cpu_berr_n; pvp = bus.cpu_vpa_n;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin : stim
      logic [23:0] a;
      logic [2:0]  fc;
      bus.cpu_a = '0; bus.cpu_as_n = 1'b1; bus.cpu_uds_n = 1'b1; bus.cpu_lds_n = 1'b1;
      bus.cpu_r_w_n = 1'b1; bus.cpu_fc = 3'b101; bus.cpu_d_out = '0;
      region_base = {24'h300000, 24'h200000, 24'h100000, 24'h000000};
      region_mask = {4{24'hF00000}};
      region_wait = {4'd5, 4'd1, 4'd2, 4'd0};
      mem_rdata = {16'h3333, 16'h2222, 16'hBEEF, 16'h1111};
      mem_ready = '0;
      irq = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_d_in", bus.cpu_d_in, 16'h0);
      check("reset_acks", {bus.cpu_dtack_n, bus.cpu_berr_n, bus.cpu_vpa_n, bus.cpu_ipl_n}, 6'b111111);
      check("reset_mem", {mem_sel, mem_rd, mem_wr, mem_be, iack_valid}, 0);
      reset = 1'b0;

      bus_cycle(24'h100040, 1'b1, 2'b00, 3'b101, 16'h0, 1, 2, 0, 1'b0);
      bus_cycle(24'h000123, 1'b0, 2'b10, 3'b101, 16'h00A5, 1, 1, 0, 1'b0);
      bus_cycle(24'hE00000, 1'b1, 2'b00, 3'b101, 16'h0, 1, 2, 0, 1'b0);
      bus_cycle(24'h200010, 1'b1, 2'b00, 3'b101, 16'h0, 1000, 1, 0, 1'b0);
      bus_cycle(24'h200010, 1'b1, 2'b00, 3'b101, 16'h0, 10, 1, 0, 1'b0);
      @(negedge clk);
      irq = 7'b0010100;
      bus_cycle(24'hFFFFFA, 1'b1, 2'b10, 3'b111, 16'h0, 1, 3, 0, 1'b0);
      bus_cycle(24'h300000, 1'b1, 2'b00, 3'b101, 16'h0, 1, 1, 3, 1'b0);
      bus_cycle(24'h100000, 1'b1, 2'b00, 3'b101, 16'h0, 1, 1, 2, 1'b1);
      bus_cycle(24'h000008, 1'b1, 2'b01, 3'b001, 16'h0, 1, 1, 0, 1'b0);

      for (int n = 0; n < 60; n++) begin
         a = 24'($urandom);
         if ($urandom_range(0, 9) < 7) a[23:20] = 4'($urandom_range(0, NR - 1));
         fc = ($urandom_range(0, 7) == 0) ? 3'b111 : 3'($urandom_range(1, 6));
         mem_rdata = {$urandom, $urandom};
         irq = 7'($urandom);
         bus_cycle(a, 1'($urandom), 2'($urandom_range(0, 2)), fc, 16'($urandom),
                   ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(1, 8),
                   $urandom_range(1, 3),
                   ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0,
                   1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/m68k_bus_ctrl.md
Name: m68k_bus_ctrl

Overview:
Parametrised 68000 bus glue between the CPU core's asynchronous-style bus (AS/UDS/LDS/DTACK) and NUM_REGIONS synchronous memory/peripheral ports. Decodes address regions, generates DTACK with per-region programmable wait states and slave ready, raises BERR on unmapped access or watchdog timeout, and answers interrupt-acknowledge cycles with VPA autovectoring. Also encodes seven interrupt request lines into the IPL bus. Sits directly beside the mc68000 wrapper in the game top level.

Parameters:
NUM_REGIONS, 4, number of decoded slave regions (1..8)
ADDR_W, 24, CPU byte-address width
WAIT_W, 4, width of per-region wait-state count
TIMEOUT, 64, max cycles in ACCESS before bus error (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cpu_a  in  ADDR_W  CPU byte address (bit 0 ignored)
cpu_as_n  in  1  address strobe
cpu_uds_n  in  1  upper data strobe
cpu_lds_n  in  1  lower data strobe
cpu_r_w_n  in  1  1=read, 0=write
cpu_fc  in  3  function code
cpu_d_out  in  16  CPU write data
cpu_d_in  out  16  read data to CPU (registered)
cpu_dtack_n  out  1  data acknowledge
cpu_berr_n  out  1  bus error
cpu_vpa_n  out  1  valid peripheral address (autovector)
cpu_ipl_n  out  3  encoded interrupt priority, active low
region_base  in  NUM_REGIONS*ADDR_W  per-region base, region r at [r*ADDR_W +: ADDR_W]
region_mask  in  NUM_REGIONS*ADDR_W  per-region compare mask (1=compare bit)
region_wait  in  NUM_REGIONS*WAIT_W  per-region wait states
mem_sel  out  NUM_REGIONS  one-hot region select
mem_rd  out  1  read strobe
mem_wr  out  1  write strobe
mem_be  out  2  byte enables {upper,lower}, active high
mem_addr  out  ADDR_W-1  word address (cpu_a[ADDR_W-1:1])
mem_wdata  out  16  write data
mem_rdata  in  NUM_REGIONS*16  per-region read data
mem_ready  in  NUM_REGIONS  per-region ready
irq  in  7  interrupt requests, bit i = level i+1
iack_valid  out  1  one-cycle pulse on interrupt acknowledge
iack_level  out  3  level being acknowledged (cpu_a[3:1])

Behaviour:
- Reset: state IDLE; dtack_n/berr_n/vpa_n=1; cpu_ipl_n=3'b111; mem_sel=0; mem_rd/mem_wr=0; mem_be=0; cpu_d_in=0; iack_valid=0; counters 0. Reset mid-cycle aborts at next edge, no ack emitted.
- All outputs registered. Cycle start T0 = edge sampling cpu_as_n=0 and (cpu_uds_n=0 or cpu_lds_n=0) in IDLE.
- Hit for region r: ((cpu_a ^ base_r) & mask_r)==0; lowest index wins on overlap.
- States IDLE, ACCESS, ACK, IACK, BERR.
- IDLE->IACK if cpu_fc==3'b111 (precedence over decode); IDLE->ACCESS on hit; IDLE->BERR on no hit.
- Entering ACCESS (T1): mem_sel[r]=1, mem_rd=cpu_r_w_n, mem_wr=~cpu_r_w_n, mem_be={~uds_n,~lds_n}, mem_addr/mem_wdata latched; wait counter=region_wait[r]; timeout counter=0. Region index latched; decode not re-evaluated.
- ACCESS: counter!=0 -> decrement. counter==0 and mem_ready[r] -> next edge: cpu_d_in<=mem_rdata[r] (reads; writes keep old value), cpu_dtack_n=0, strobes/sel cleared, ->ACK. DTACK latency = 2+W cycles after T0 with ready high.
- Timeout counter increments each ACCESS cycle; reaching TIMEOUT-1 without completion -> BERR, strobes/sel cleared. Completion and timeout same cycle: completion wins.
- cpu_as_n=1 during ACCESS (abort): clear strobes/sel, ->IDLE, no DTACK/BERR.
- ACK/BERR/IACK: hold respective strobe low until cpu_as_n sampled 1; then deassert next edge, ->IDLE. A new cycle cannot begin the same edge AS rises.
- IACK: cpu_vpa_n=0 from T1; iack_valid pulses exactly at T1; iack_level=cpu_a[3:1] held while in IACK. Memory strobes never asserted.
- IPL: cpu_ipl_n = ~(highest set irq index+1), 0 requests -> 3'b111; 1-cycle registered latency, independent of bus FSM.

Decomposition:
- Package m68k_bus_pkg: state encoding, FC_IACK=3'b111, IPL_NONE=3'b111.
- Sub-module m68k_ipl_encoder (irq[7:1] -> registered ipl_n, own clk/reset).

Test Plan:
- Read region 1 (base 0x100000, mask 0xF00000, wait 2, ready=1), rdata=0xBEEF -> mem_sel=4'b0010 at T1, dtack_n low at T4, cpu_d_in=0xBEEF, dtack_n high one cycle after as_n rises.
- Write byte lower to region 0 wait 0, d_out=0x00A5 -> mem_wr=1, mem_be=2'b01, mem_wdata=0x00A5, dtack_n low at T2.
- Access 0xE00000 (no region hits) -> berr_n low at T1, mem_sel stays 0, released after as_n rises.
- Region 2 with mem_ready held 0 -> berr_n low after TIMEOUT cycles, sel cleared; repeat with ready raised at cycle 10 -> dtack, no berr.
- fc=3'b111, a[3:1]=5 -> vpa_n low at T1, iack_valid one pulse, iack_level=5, no mem strobes; irq=7'b0010100 -> ipl_n=3'b010 one cycle later.
- Assert reset during ACCESS and as_n abort during wait -> all strobes idle next edge, no dtack_n/berr_n pulse.
